// File: rtl/systolic_drain.sv
// Output-side drain for the systolic array. It captures each skewed accumulator lane
// at its settle cycle, clears the array, and streams the lanes out as words.
module systolic_drain #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int KW    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic [N*ACC_W-1:0] macout,
  output logic               acc_clr,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               overrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = KW + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);
  localparam logic [CW-1:0] LANES_M1 = CW'(N - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, SEND} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [KW-1:0]     k_reg;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     lane;
  logic [ACC_W-1:0]  cap [N];
  logic [CW-1:0]     t0;

  // Lane 0 settles k_len + N - 1 cycles after start; each later lane one cycle after that.
  assign t0 = {2'b00, k_reg} + LANES_M1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      k_reg     <= '0;
      idx       <= '0;
      lane      <= '0;
      acc_clr   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N; i++) cap[i] <= '0;
    end else begin
      if (start && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            k_reg <= (k_len == '0) ? KW'(1) : k_len;
            cnt   <= ONE_CNT;
            busy  <= 1'b1;
            state <= WAIT;
          end
        end

        WAIT: begin
          cnt <= cnt + ONE_CNT;
          if (cnt == t0) begin
            cap[0] <= macout[ACC_W-1:0];
            if (N == 1) begin
              state     <= SEND;
              idx       <= '0;
              out_valid <= 1'b1;
              acc_clr   <= 1'b1;
              out_data  <= macout[ACC_W-1:0];
              out_last  <= 1'b1;
            end else begin
              lane  <= ONE_IDX;
              state <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          cnt       <= cnt + ONE_CNT;
          cap[lane] <= macout[ACC_W*lane +: ACC_W];
          if (lane == LAST_IDX) begin
            state     <= SEND;
            idx       <= '0;
            out_valid <= 1'b1;
            acc_clr   <= 1'b1;
            out_data  <= cap[0];
            out_last  <= 1'b0;
          end else begin
            lane <= lane + ONE_IDX;
          end
        end

        SEND: begin
          acc_clr <= 1'b0;
          // Word and flags advance only on a completed handshake, so a stalled word holds.
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
            end else begin
              idx      <= idx + ONE_IDX;
              out_data <= cap[idx + ONE_IDX];
              out_last <= ((idx + ONE_IDX) == LAST_IDX);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: every macout lane carries the current tile cycle
// number, so each captured word equals the cycle in which its lane was sampled.
module tb_systolic_drain;

  localparam int N     = 4;
  localparam int ACC_W = 32;
  localparam int KW    = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic [KW-1:0]      k_len;
  logic [N*ACC_W-1:0] macout;
  logic               acc_clr;
  logic [ACC_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               overrun;

  systolic_drain #(.N(N), .ACC_W(ACC_W), .KW(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .macout    (macout),
    .acc_clr   (acc_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] d_hist   [64];
  logic        v_hist   [64];
  logic        b_hist   [64];
  logic        clr_hist [64];
  logic        ovr_hist [64];
  logic [31:0] words [$];
  int          wcyc  [$];
  logic [31:0] lastw [$];
  int          clr_count;
  int          clr_cyc;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic driveLanes(input int value);
    for (int i = 0; i < N; i++) macout[ACC_W*i +: ACC_W] = ACC_W'(value);
  endtask

  // Holds reset for two cycles (checking reset outputs), then releases it for one idle edge.
  task automatic doReset();
    reset = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1; driveLanes(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_acc_clr", {31'd0, acc_clr}, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_last", {31'd0, out_last}, 0);
    checkOutput("rst_overrun", {31'd0, overrun}, 0);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one tile from cycle 0 (start) for ncyc cycles, recording outputs per cycle.
  task automatic applyStimulus(input int k, input int stall_lo, input int stall_hi,
                               input int restart_at, input int restart_k,
                               input int reset_at, input int ncyc);
    words.delete(); wcyc.delete(); lastw.delete();
    clr_count = 0; clr_cyc = -1;
    start = 1'b1; k_len = KW'(k); reset = 1'b0;
    out_ready = !(0 >= stall_lo && 0 <= stall_hi);
    driveLanes(0);
    for (int c = 0; c < ncyc; c++) begin
      d_hist[c] = out_data; v_hist[c] = out_valid; b_hist[c] = busy;
      clr_hist[c] = acc_clr; ovr_hist[c] = overrun;
      if (acc_clr) begin clr_count++; clr_cyc = c; end
      if (out_valid && out_ready) begin
        words.push_back(out_data);
        wcyc.push_back(c);
        if (out_last) lastw.push_back(out_data);
      end
      @(posedge clk); #1;
      start     = (c + 1 == restart_at);
      k_len     = (c + 1 == restart_at) ? KW'(restart_k) : KW'(k);
      reset     = (c + 1 == reset_at);
      out_ready = !((c + 1) >= stall_lo && (c + 1) <= stall_hi);
      driveLanes(c + 1);
    end
    start = 1'b0; reset = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; k_len = '0; out_ready = 1'b1; macout = '0;

    // Basic drain, k_len = 4
    doReset();
    applyStimulus(4, 100, 100, -1, 0, -1, 18);
    checkOutput("basic_nwords", words.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("basic_word%0d", i), words[i], 7 + i);
      checkOutput($sformatf("basic_cyc%0d", i), wcyc[i], 11 + i);
    end
    checkOutput("basic_nlast", lastw.size(), 1);
    checkOutput("basic_lastval", lastw[0], 10);
    checkOutput("basic_clr_count", clr_count, 1);
    checkOutput("basic_clr_cyc", clr_cyc, 11);
    checkOutput("basic_busy_c0", {31'd0, b_hist[0]}, 0);
    checkOutput("basic_busy_c1", {31'd0, b_hist[1]}, 1);
    checkOutput("basic_busy_c14", {31'd0, b_hist[14]}, 1);
    checkOutput("basic_busy_c15", {31'd0, b_hist[15]}, 0);
    checkOutput("basic_valid_c10", {31'd0, v_hist[10]}, 0);

    // Backpressure: ready low for cycles 11..13
    doReset();
    applyStimulus(4, 11, 13, -1, 0, -1, 20);
    for (int c = 11; c <= 14; c++) begin
      checkOutput($sformatf("bp_hold_data_c%0d", c), d_hist[c], 7);
      checkOutput($sformatf("bp_hold_valid_c%0d", c), {31'd0, v_hist[c]}, 1);
    end
    checkOutput("bp_nwords", words.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("bp_word%0d", i), words[i], 7 + i);
      checkOutput($sformatf("bp_cyc%0d", i), wcyc[i], 14 + i);
    end
    checkOutput("bp_clr_count", clr_count, 1);
    checkOutput("bp_clr_cyc", clr_cyc, 11);

    // k_len = 0 behaves as k_len = 1
    doReset();
    applyStimulus(0, 100, 100, -1, 0, -1, 14);
    checkOutput("k0_nwords", words.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("k0_word%0d", i), words[i], 4 + i);
      checkOutput($sformatf("k0_cyc%0d", i), wcyc[i], 8 + i);
    end
    checkOutput("k0_clr_cyc", clr_cyc, 8);

    // Overrun: second start at cycle 5
    doReset();
    applyStimulus(4, 100, 100, 5, 4, -1, 20);
    checkOutput("ovr_c5", {31'd0, ovr_hist[5]}, 0);
    checkOutput("ovr_c6", {31'd0, ovr_hist[6]}, 1);
    checkOutput("ovr_c19", {31'd0, ovr_hist[19]}, 1);
    checkOutput("ovr_nwords", words.size(), 4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("ovr_word%0d", i), words[i], 7 + i);
    checkOutput("ovr_busy_c16", {31'd0, b_hist[16]}, 0);

    // Reset mid-SEND in cycle 12, then a fresh tile
    doReset();
    applyStimulus(4, 100, 100, -1, 0, 12, 16);
    checkOutput("rms_word0", words[0], 7);
    checkOutput("rms_word0_cyc", wcyc[0], 11);
    checkOutput("rms_valid_c13", {31'd0, v_hist[13]}, 0);
    checkOutput("rms_busy_c13", {31'd0, b_hist[13]}, 0);
    checkOutput("rms_clr_c13", {31'd0, clr_hist[13]}, 0);
    checkOutput("rms_clr_count", clr_count, 1);
    applyStimulus(4, 100, 100, -1, 0, -1, 18);
    checkOutput("rms2_nwords", words.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rms2_word%0d", i), words[i], 7 + i);
      checkOutput($sformatf("rms2_cyc%0d", i), wcyc[i], 11 + i);
    end

    // Back-to-back: second start (k_len = 2) at cycle 15
    doReset();
    applyStimulus(4, 100, 100, 15, 2, -1, 32);
    checkOutput("b2b_nwords", words.size(), 8);
    checkOutput("b2b_ovr_c16", {31'd0, ovr_hist[16]}, 0);
    checkOutput("b2b_ovr_c31", {31'd0, ovr_hist[31]}, 0);
    checkOutput("b2b_busy_c16", {31'd0, b_hist[16]}, 1);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("b2b_word%0d", 4 + i), words[4 + i], 20 + i);
      checkOutput($sformatf("b2b_cyc%0d", 4 + i), wcyc[4 + i], 24 + i);
    end
    checkOutput("b2b_nlast", lastw.size(), 2);
    checkOutput("b2b_last2", lastw[1], 23);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
